// File: rtl/pip_reg_pkg.sv
// Shared types and default widths for the elastic pipeline register.
package pip_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned PIP_DATA_W = 64;
  localparam int unsigned PIP_CTRL_W = 2;
  localparam int unsigned PIP_CNT_W  = 16;

endpackage

// File: rtl/pip_reg_slot.sv
// One {ctrl, data} storage entry: reset clears both, i_clr_ctrl clears ctrl only.
module pip_reg_slot #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_load,
  input  logic              i_clr_ctrl,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clr_ctrl) begin
      // Data is left alone on a clear; only the control bits must drop.
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pip_reg_elastic.sv
// Two-entry elastic (skid) pipeline register with registered in_ready.
// Optional stall/bubble counters are built when PIP_REG_PERF_EN is defined.
module pip_reg_elastic
  import pip_reg_pkg::*;
#(
  parameter int unsigned DATA_W = PIP_DATA_W,
  parameter int unsigned CTRL_W = PIP_CTRL_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIP_REG_PERF_EN
  ,
  output logic [PIP_CNT_W-1:0] stall_cnt,
  output logic [PIP_CNT_W-1:0] bubble_cnt
`endif
);

  state_t r_state, w_state_nxt;
  logic   r_in_ready;
  logic   w_push, w_pop;
  logic   w_main_load, w_main_sel_skid, w_skid_load;

  logic [CTRL_W-1:0] w_skid_ctrl, w_main_ctrl_in;
  logic [DATA_W-1:0] w_skid_data, w_main_data_in;

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = r_in_ready;
  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_load     = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    if (Flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_push) begin
            w_state_nxt = FULL;
            w_skid_load = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_state_nxt     = ONE;
            w_main_load     = 1'b1;
            w_main_sel_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  assign w_main_ctrl_in = w_main_sel_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_sel_skid ? w_skid_data : in_data;

  pip_reg_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clk       (clk),
    .Reset     (Reset),
    .i_load    (w_main_load),
    .i_clr_ctrl(Flush),
    .i_ctrl    (w_main_ctrl_in),
    .i_data    (w_main_data_in),
    .o_ctrl    (out_ctrl),
    .o_data    (out_data)
  );

  pip_reg_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid (
    .clk       (clk),
    .Reset     (Reset),
    .i_load    (w_skid_load),
    .i_clr_ctrl(Flush),
    .i_ctrl    (in_ctrl),
    .i_data    (in_data),
    .o_ctrl    (w_skid_ctrl),
    .o_data    (w_skid_data)
  );

`ifdef PIP_REG_PERF_EN
  logic [PIP_CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      // A flush is a bubble only if it throws away something real.
      if (Flush && (out_valid || w_push) && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pip_reg_elastic.sv
// Bench for pip_reg_elastic: a 2-deep FIFO queue model plus counter model.
module tb_pip_reg_elastic;

  localparam int DW = 64;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          Reset, Flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
`ifdef PIP_REG_PERF_EN
  logic [15:0]   stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [CW+DW-1:0] mq[$];
  int m_stall  = 0;
  int m_bubble = 0;

  always #5 clk = ~clk;

  pip_reg_elastic #(
    .DATA_W(DW),
    .CTRL_W(CW)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Flush     (Flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIP_REG_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Drive one cycle, advance the model by the queue rules, sample at posedge+1.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic rdy, input logic fl, input logic rs);
    int  n;
    bit  push, pop;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = rdy;
    Flush     = fl;
    Reset     = rs;
    n    = mq.size();
    push = v && (n < 2);
    pop  = (n > 0) && rdy;
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (n > 0 && !rdy && m_stall < 65535) m_stall++;
      if (fl && (n > 0 || push) && m_bubble < 65535) m_bubble++;
      if (fl) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({c, d});
      end
    end
  endtask

  task automatic test_reset;
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL reset: valid=%b ready=%b ctrl=%h data=%h, want 0 1 0 0",
               out_valid, in_ready, out_ctrl, out_data);
    end
  endtask

  task automatic test_stream;
    for (int i = 1; i <= 8; i++) begin
      step(1, CW'(i), DW'(i), 1, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(i)) begin
        n_errors++;
        $display("FAIL stream[%0d]: valid=%b data=%h ctrl=%h, want 1 %h %h",
                 i, out_valid, out_data, out_ctrl, DW'(i), CW'(i));
      end
    end
    step(0, '0, '0, 1, 0, 0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stream_drain: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    step(1, 2'd1, 64'hA, 0, 0, 0);
    n_checks++;
    if (out_data !== 64'hA || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_first: data=%h ready=%b, want a 1", out_data, in_ready);
    end
    step(1, 2'd2, 64'hB, 0, 0, 0);
    n_checks++;
    if (out_data !== 64'hA || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_full: data=%h ready=%b valid=%b, want a 0 1",
               out_data, in_ready, out_valid);
    end
    step(1, 2'd3, 64'hD, 0, 0, 0);
    n_checks++;
    if (out_data !== 64'hA || out_ctrl !== 2'd1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_hold: data=%h ctrl=%h ready=%b, want a 1 0",
               out_data, out_ctrl, in_ready);
    end
    step(0, '0, '0, 1, 0, 0);
    n_checks++;
    if (out_data !== 64'hB || out_ctrl !== 2'd2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_second: data=%h ctrl=%h ready=%b valid=%b, want b 2 1 1",
               out_data, out_ctrl, in_ready, out_valid);
    end
    step(0, '0, '0, 1, 0, 0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush_full;
    step(1, 2'd1, 64'hA, 0, 0, 0);
    step(1, 2'd2, 64'hB, 0, 0, 0);
    step(1, 2'd3, 64'hC, 0, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0) begin
      n_errors++;
      $display("FAIL flush: valid=%b ready=%b ctrl=%h, want 0 1 0",
               out_valid, in_ready, out_ctrl);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, '0, 1, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_leak[%0d]: valid=%b data=%h, want valid 0", i, out_valid, out_data);
      end
    end
`ifdef PIP_REG_PERF_EN
    n_checks++;
    if (bubble_cnt !== 16'(m_bubble)) begin
      n_errors++;
      $display("FAIL flush_bubble: bubble_cnt=%0d, want %0d", bubble_cnt, m_bubble);
    end
`endif
  endtask

  task automatic test_reset_flush;
    step(1, 2'd1, 64'h5, 0, 0, 0);
    step(1, 2'd2, 64'h6, 0, 1, 1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL rst_flush: valid=%b ready=%b ctrl=%h data=%h, want 0 1 0 0",
               out_valid, in_ready, out_ctrl, out_data);
    end
`ifdef PIP_REG_PERF_EN
    n_checks++;
    if (bubble_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL rst_flush_cnt: bubble=%0d stall=%0d, want 0 0", bubble_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_random;
    logic [CW+DW-1:0] front;
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(3) != 0), CW'($urandom), {$urandom, $urandom},
           ($urandom_range(2) != 0), ($urandom_range(24) == 0), 1'b0);
      n_checks++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin
        n_errors++;
        $display("FAIL rand_hs[%0d]: valid=%b ready=%b, want %b %b", i, out_valid, in_ready,
                 (mq.size() != 0), (mq.size() < 2));
      end
      if (mq.size() != 0) begin
        front = mq[0];
        n_checks++;
        if ({out_ctrl, out_data} !== front) begin
          n_errors++;
          $display("FAIL rand_data[%0d]: got %h, want %h", i, {out_ctrl, out_data}, front);
        end
      end
`ifdef PIP_REG_PERF_EN
      n_checks++;
      if (stall_cnt !== 16'(m_stall) || bubble_cnt !== 16'(m_bubble)) begin
        n_errors++;
        $display("FAIL rand_cnt[%0d]: stall=%0d bubble=%0d, want %0d %0d",
                 i, stall_cnt, bubble_cnt, m_stall, m_bubble);
      end
`endif
    end
  endtask

`ifdef PIP_REG_PERF_EN
  task automatic test_stall_sat;
    step(0, '0, '0, 0, 0, 1);
    step(1, 2'd1, 64'h77, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, '0, '0, 0, 0, 0);
    n_checks++;
    if (stall_cnt !== 16'hFFFF || m_stall != 65535 || out_data !== 64'h77) begin
      n_errors++;
      $display("FAIL stall_sat: stall_cnt=%h data=%h, want ffff 77", stall_cnt, out_data);
    end
  endtask
`endif

  initial begin
    Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush_full();
    test_reset_flush();
    test_random();
`ifdef PIP_REG_PERF_EN
    test_stall_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
